monitor_sensores: RTL and testbench
===================================

# monitor_sensores

Upstream conditioning stage for the tank-level controller. Synchronises and debounces the raw upper/lower level switches, supervises valve feedback against level progress, and drives the debounced `upper` and latched `erro` inputs consumed by the level FSM. Errors stay latched until an operator acknowledge clears them and no fault condition remains.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required before a filtered sensor output changes; legal range ≥ 2.
- `TIMEOUT`, default 16: consecutive cycles with valve open and level count unchanged that raise the valve fault; legal range ≥ 2.
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `upper_raw`, in, 1: raw upper level switch, asynchronous.
- `lower_raw`, in, 1: raw lower level switch, asynchronous.
- `valve_e`, in, 1: inlet valve state fed back from the level FSM.
- `count`, in, 3: level count fed back from the level FSM.
- `ack`, in, 1: synchronous fault acknowledge, level-sensitive.
- `upper`, out, 1: debounced upper switch.
- `lower`, out, 1: debounced lower switch.
- `erro`, out, 1: latched fault flag.
- `erro_code`, out, 2: sticky cause. Bit 0 = sensor inconsistency; bit 1 = valve timeout.

## Operation
- Filters (one per sensor): 2-FF synchroniser feeding a stability counter. The counter increments while the synchronised value ≠ output and clears when they are equal. When it reaches `DEB_CYCLES` - 1 with the mismatch still present, the output takes the new value and the counter clears. Pulses shorter than `DEB_CYCLES` cycles never reach the output.
- Inconsistency condition `c_inc`: `upper`=1 and `lower`=0, evaluated on the filtered outputs.
- Valve timer:
  - `count_q` registers `count` every cycle.
  - If `valve_e`=1 and `count`==`count_q`, the timer increments, saturating at `TIMEOUT`. Otherwise it clears.
  - `c_to` = (timer==`TIMEOUT`).
- FSM states:
  - NORMAL: `erro`=0. If `c_inc` or `c_to`, go to FALHA and load `erro_code` = {`c_to`, `c_inc`}.
  - FALHA: `erro`=1. Newly active conditions OR into `erro_code`.
  - FALHA to NORMAL: only when `ack`=1 and neither `c_inc` nor `c_to` is active; `erro_code` clears to 0.
  - `ack` while any condition is active: stay in FALHA, code keeps accumulating.
- `ack` in NORMAL: no effect.
- Simultaneous `c_inc` and `c_to`: `erro_code`=11.

## Timing
- Reset values: `upper`=0, `lower`=0, `erro`=0, `erro_code`=00. Synchronisers, counters, timer and `count_q` are 0; state is NORMAL.
- Reset asserted mid-operation: immediate return to the values above, including from FALHA. Filtering restarts from 0 after release.
- Sensor latency: if edge N is the first edge that samples a new raw level, the filtered output changes on edge N+1+`DEB_CYCLES`.
- Fault latency: `erro` and `erro_code` update on the first edge at which `c_inc` or `c_to` is true. They are registered, so visible one cycle after the condition is established.
- Timeout: with `valve_e`=1 and `count` frozen, `erro` rises `TIMEOUT`+1 edges after the first frozen cycle.
- Any `count` change restarts the timer.
- Clear: `erro` falls on the edge sampling `ack`=1 with conditions inactive.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `MONITOR_WATCHDOG_VALVULA_EN`.
- Defined: valve timer, `count_q` and `c_to` are present as described.
- Undefined: no timer logic is built, `c_to` is tied to 0, and `erro_code[1]` stays 0 permanently.
- Sensor filtering and the inconsistency check are unaffected in both cases.

## Structure
- Shared package `caixa_pkg`:
  - FSM state encoding (NORMAL=0, FALHA=1).
  - Error-code bit constants `ERR_INC`=0 and `ERR_TO`=1.
  - Level count width constant (3).
- Sub-module `filtro_sensor`, parameterised by `DEB_CYCLES`, containing the synchroniser and stability counter; instantiated twice.
- Top level: timer, `count_q`, FSM and output registers.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `TIMEOUT`=16.
1. Reset mid-FALHA -> all outputs 0 asynchronously, state NORMAL after release.
2. `upper_raw` 3-cycle glitch -> `upper` stays 0. `upper_raw` held high -> `upper`=1 on edge N+5.
3. `upper_raw`=1 and `lower_raw`=0 held -> `erro`=1, `erro_code`=01. `ack` while inconsistent -> stays 01. Sensors fixed, then `ack` -> `erro`=0, code 00.
4. `valve_e`=1 with `count` frozen at 3 -> `erro`=1 and code 10 after 17 edges. `count` toggling every 10 cycles -> no fault.
5. Both faults together -> code 11. `ack` held until both clear -> return to NORMAL on the first edge with both conditions inactive.
6. With macro undefined, rerun scenario 4 -> `erro` stays 0 and `erro_code[1]`=0 throughout.

Source files
------------

// File: rtl/caixa_pkg.sv
// Shared definitions for the tank-level sensor monitor.
//   estado_t : supervisor FSM encoding (NORMAL=0, FALHA=1)
//   ERR_INC  : erro_code bit for sensor inconsistency
//   ERR_TO   : erro_code bit for valve timeout
//   COUNT_W  : width of the level count fed back from the level FSM
package caixa_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FALHA  = 1'b1
  } estado_t;

  localparam int ERR_INC = 0;
  localparam int ERR_TO  = 1;
  localparam int COUNT_W = 3;

endpackage

// File: rtl/filtro_sensor.sv
// Synchroniser plus debounce filter for one raw level switch.
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high
//   raw      : asynchronous switch input
//   filtered : debounced level, changes only after DEB_CYCLES stable samples
module filtro_sensor #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // cnt holds the number of consecutive mismatching samples already seen;
  // the DEB_CYCLES-th mismatch commits the new level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (sync_2 != filtered) begin
      if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        filtered <= sync_2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/monitor_sensores.sv
// Sensor conditioning and fault supervisor for the tank-level controller.
// Debounces the upper/lower switches, flags inconsistent switch states and
// (optionally) a valve that stays open without level progress. Faults are
// latched until ack arrives while no condition is active.
// Optional feature macro: MONITOR_WATCHDOG_VALVULA_EN enables the valve
// watchdog; when undefined c_to is 0 and erro_code[1] never sets.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   upper_raw, lower_raw : raw asynchronous level switches
//   valve_e, count       : valve state and level count from the level FSM
//   ack                  : level-sensitive fault acknowledge
//   upper, lower         : debounced switches
//   erro, erro_code      : latched fault flag and sticky cause bits
module monitor_sensores
  import caixa_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               upper_raw,
  input  logic               lower_raw,
  input  logic               valve_e,
  input  logic [COUNT_W-1:0] count,
  input  logic               ack,
  output logic               upper,
  output logic               lower,
  output logic               erro,
  output logic [1:0]         erro_code
);

  estado_t    state;
  logic       c_inc;
  logic       c_to;
  logic [1:0] cond;

  filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_upper (
    .clock    (clock),
    .reset    (reset),
    .raw      (upper_raw),
    .filtered (upper)
  );

  filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_lower (
    .clock    (clock),
    .reset    (reset),
    .raw      (lower_raw),
    .filtered (lower)
  );

  // Upper switch wet while lower switch dry is physically impossible.
  assign c_inc = upper & ~lower;

`ifdef MONITOR_WATCHDOG_VALVULA_EN
  localparam int TIM_W = $clog2(TIMEOUT + 1);

  logic [COUNT_W-1:0] count_q;
  logic [TIM_W-1:0]   timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      timer   <= '0;
    end else begin
      count_q <= count;
      if (valve_e && (count == count_q)) begin
        if (timer != TIM_W'(TIMEOUT)) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
    end
  end

  assign c_to = (timer == TIM_W'(TIMEOUT));
`else
  logic unused_watchdog_inputs;
  assign unused_watchdog_inputs = ^{valve_e, count};
  assign c_to = 1'b0;
`endif

  always_comb begin
    cond          = '0;
    cond[ERR_INC] = c_inc;
    cond[ERR_TO]  = c_to;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= NORMAL;
      erro      <= 1'b0;
      erro_code <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (c_inc || c_to) begin
            state     <= FALHA;
            erro      <= 1'b1;
            erro_code <= cond;
          end
        end
        FALHA: begin
          // ack is honoured only once every cause has gone away.
          if (ack && !c_inc && !c_to) begin
            state     <= NORMAL;
            erro      <= 1'b0;
            erro_code <= '0;
          end else begin
            erro_code <= erro_code | cond;
          end
        end
        default: begin
          state     <= NORMAL;
          erro      <= 1'b0;
          erro_code <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_sensores.sv
module tb_monitor_sensores;

  localparam int DEB = 4;
  localparam int TO  = 16;
`ifdef MONITOR_WATCHDOG_VALVULA_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       upper_raw = 1'b0, lower_raw = 1'b0, valve_e = 1'b0, ack = 1'b0;
  logic [2:0] count = 3'd0;
  logic       upper, lower, erro;
  logic [1:0] erro_code;

  int n_checks = 0;
  int n_fail   = 0;

  monitor_sensores #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .upper_raw (upper_raw),
    .lower_raw (lower_raw),
    .valve_e   (valve_e),
    .count     (count),
    .ack       (ack),
    .upper     (upper),
    .lower     (lower),
    .erro      (erro),
    .erro_code (erro_code)
  );

  always #5 clock = ~clock;

  // Reference model: switch levels delayed two samples, a level is accepted
  // when the last DEB samples seen all disagree with the current output;
  // the valve fault is active when each of the last TO edges saw the valve
  // open with an unchanged count.
  bit       m_pipe_u [2];
  bit       m_pipe_l [2];
  bit       m_hist_u [$];
  bit       m_hist_l [$];
  bit       m_frozen [$];
  bit [2:0] m_prev_count;
  bit       mu, ml, me, m_fault;
  bit [1:0] mcode;

  function automatic void model_reset();
    m_pipe_u = '{0, 0};
    m_pipe_l = '{0, 0};
    m_hist_u.delete();
    m_hist_l.delete();
    m_frozen.delete();
    m_prev_count = 3'd0;
    mu = 0; ml = 0; me = 0; m_fault = 0; mcode = 2'b00;
  endfunction

  function automatic bit all_differ(bit h[$], bit v, int n);
    if (h.size() < n) return 0;
    foreach (h[i]) if (h[i] == v) return 0;
    return 1;
  endfunction

  function automatic void model_edge(bit ur, bit lr, bit v, bit [2:0] c, bit a);
    bit cinc, cto, frz;
    bit [1:0] cnow;
    cinc = mu & ~ml;
    cto  = 0;
    if (WD) begin
      cto = (m_frozen.size() == TO);
      foreach (m_frozen[i]) if (!m_frozen[i]) cto = 0;
    end
    cnow = {cto, cinc};
    if (!m_fault) begin
      if (cnow != 0) begin m_fault = 1; me = 1; mcode = cnow; end
    end else if (a && cnow == 0) begin
      m_fault = 0; me = 0; mcode = 0;
    end else begin
      mcode = mcode | cnow;
    end
    m_hist_u.push_back(m_pipe_u[1]);
    m_hist_l.push_back(m_pipe_l[1]);
    if (m_hist_u.size() > DEB) void'(m_hist_u.pop_front());
    if (m_hist_l.size() > DEB) void'(m_hist_l.pop_front());
    if (all_differ(m_hist_u, mu, DEB)) mu = ~mu;
    if (all_differ(m_hist_l, ml, DEB)) ml = ~ml;
    m_pipe_u[1] = m_pipe_u[0]; m_pipe_u[0] = ur;
    m_pipe_l[1] = m_pipe_l[0]; m_pipe_l[0] = lr;
    frz = v && (c == m_prev_count);
    m_frozen.push_back(frz);
    if (m_frozen.size() > TO) void'(m_frozen.pop_front());
    m_prev_count = c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ur, input bit lr, input bit v, input bit [2:0] c, input bit a);
    upper_raw = ur; lower_raw = lr; valve_e = v; count = c; ack = a;
    @(posedge clock);
    model_edge(ur, lr, v, c, a);
    #1;
    check("model", {27'd0, upper, lower, erro, erro_code}, {27'd0, mu, ml, me, mcode});
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check("async_reset", {27'd0, upper, lower, erro, erro_code}, 32'd0);
    upper_raw = 0; lower_raw = 0; valve_e = 0; count = 0; ack = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit ur; bit lr; bit v; bit [2:0] c; bit a; int n;
    bit eu; bit el; bit ee; bit [1:0] ec;
  } vec_t;

  vec_t tbl[8];
  bit   seen_up;
  int   k;
  bit   r_ur, r_lr, r_v, r_a;
  bit [2:0] r_c;

  initial begin
    tbl[0] = '{0, 0, 0, 3'd0, 0, 8, 0, 0, 0, 2'b00};
    tbl[1] = '{1, 0, 0, 3'd0, 0, 8, 1, 0, 1, 2'b01};
    tbl[2] = '{1, 0, 0, 3'd0, 1, 3, 1, 0, 1, 2'b01};
    tbl[3] = '{1, 1, 0, 3'd0, 0, 8, 1, 1, 1, 2'b01};
    tbl[4] = '{1, 1, 0, 3'd0, 1, 1, 1, 1, 0, 2'b00};
    tbl[5] = '{0, 1, 0, 3'd0, 0, 8, 0, 1, 0, 2'b00};
    tbl[6] = '{0, 0, 0, 3'd0, 0, 8, 0, 0, 0, 2'b00};
    tbl[7] = '{0, 0, 0, 3'd0, 1, 2, 0, 0, 0, 2'b00};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check("reset_upper", {31'd0, upper}, 0);
    check("reset_lower", {31'd0, lower}, 0);
    check("reset_erro", {31'd0, erro}, 0);
    check("reset_code", {30'd0, erro_code}, 0);

    // Table-driven sensor / inconsistency / ack sequences
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].ur, tbl[i].lr, tbl[i].v, tbl[i].c, tbl[i].a);
      check($sformatf("tbl%0d_upper", i), {31'd0, upper}, {31'd0, tbl[i].eu});
      check($sformatf("tbl%0d_lower", i), {31'd0, lower}, {31'd0, tbl[i].el});
      check($sformatf("tbl%0d_erro", i), {31'd0, erro}, {31'd0, tbl[i].ee});
      check($sformatf("tbl%0d_code", i), {30'd0, erro_code}, {30'd0, tbl[i].ec});
    end

    // 3-cycle glitch never reaches the output
    seen_up = 0;
    for (int j = 0; j < 3; j++) begin step(1, 0, 0, 0, 0); seen_up |= upper; end
    for (int j = 0; j < 10; j++) begin step(0, 0, 0, 0, 0); seen_up |= upper; end
    check("glitch_upper", {31'd0, seen_up}, 0);

    // Latency: first sampling edge N, output changes on N+5
    for (int j = 1; j <= 5; j++) step(1, 1, 0, 0, 0);
    check("latency_before", {31'd0, upper}, 0);
    step(1, 1, 0, 0, 0);
    check("latency_at", {31'd0, upper}, 1);
    for (int j = 0; j < 8; j++) step(0, 0, 0, 0, 0);

    // Valve frozen at 3: fault after 18 steps (first frozen edge is step 2)
    do_reset();
    for (int j = 1; j <= 17; j++) step(0, 0, 1, 3'd3, 0);
    check("to_before", {31'd0, erro}, 0);
    step(0, 0, 1, 3'd3, 0);
    check("to_erro", {31'd0, erro}, {31'd0, WD});
    check("to_code", {30'd0, erro_code}, WD ? 32'd2 : 32'd0);
    for (int j = 0; j < 3; j++) step(0, 0, 1, 3'd4, 1);
    check("to_clear", {31'd0, erro}, 0);
    seen_up = 0;
    for (int j = 0; j < 60; j++) begin
      step(0, 0, 1, 3'((j / 10) % 2 + 5), 0);
      seen_up |= erro;
    end
    check("toggle_no_fault", {31'd0, seen_up}, 0);

    // Both faults together, then ack held until both clear
    do_reset();
    for (int j = 0; j < 20; j++) step(1, 0, 1, 3'd5, 0);
    check("both_code", {30'd0, erro_code}, WD ? 32'd3 : 32'd1);
    k = 0;
    while (erro && k < 20) begin
      step(0, 0, 1, 3'(k), 1);
      k++;
    end
    check("both_clear_bound", {31'd0, erro}, 0);

    // Async reset while in FALHA
    for (int j = 0; j < 10; j++) step(1, 0, 0, 0, 0);
    check("falha_before_reset", {31'd0, erro}, 1);
    do_reset();
    for (int j = 0; j < 4; j++) step(0, 0, 0, 0, 0);
    check("after_reset_erro", {31'd0, erro}, 0);

    // Randomised run against the model
    r_ur = 0; r_lr = 0; r_v = 1; r_c = 0;
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 6) == 0) r_ur = ~r_ur;
      if ($urandom_range(0, 6) == 0) r_lr = ~r_lr;
      if ($urandom_range(0, 15) == 0) r_v = ~r_v;
      if ($urandom_range(0, 24) == 0) r_c = 3'($urandom_range(0, 7));
      r_a = ($urandom_range(0, 3) == 0);
      step(r_ur, r_lr, r_v, r_c, r_a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
